decode_seq_ctrl: RTL and testbench
==================================

// Module: decode_seq_ctrl
// PURPOSE
//  Sequencer/controller for the decode stage: owns the fetch->decode byte handshake, the output
//  pipe register, and the halt/interrupt/flush state machine. Sits between the fetch buffer and the
//  decode datapath, which returns instruction length and class combinationally.
// PARAMETERS
//  IADDRW      32  instruction address width
//  MAXLEN      15  longest legal x86 instruction in bytes
//  INT_CYCLES  2   cycles held in INT state before decode resumes (1..15)
//  CNTW        16  width of the starved-cycle counter
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  flush          in   1       squash all decode state this cycle
//  handle_int     in   1       interrupt request
//  halt           out  1       processor halted (HLT retired from decode)
//  f_valid        in   1       fetch window valid
//  f_valid_bytes  in   6       valid bytes in fetch window (0..32)
//  f_pc           in   IADDRW  address of byte 0 of window
//  f_ready        out  1       window consumed this cycle
//  f_bytes_read   out  6       bytes consumed (0 when f_ready=0)
//  dc_length      in   4       decoded length of instruction at window byte 0
//  dc_is_hlt      in   1       instruction is HLT (F4)
//  dc_is_call     in   1       instruction is CALL
//  d_valid        out  1       decoded instruction held in output register
//  d_ready        in   1       downstream accepts
//  d_pc           out  IADDRW  pc of held instruction
//  d_len          out  4       length of held instruction
//  ras_push       out  1       one-cycle push pulse to return address stack
//  ras_address    out  IADDRW  return address = pc + length of the CALL
//  starve_cnt     out  CNTW    saturating count of cycles with f_valid && too few bytes
// BEHAVIOUR
//  States: RUN, HALT, INT, FLUSH. On reset: state=RUN, every output 0.
//  fire = state==RUN && f_valid && 1<=dc_length<=MAXLEN && dc_length<=f_valid_bytes
//         && (!d_valid || d_ready) && !flush.
//  f_ready=fire and f_bytes_read=fire?dc_length:0. Both are combinational; consumption takes 0 cycles.
//  Output register: on fire, next edge d_valid=1, d_pc=f_pc, d_len=dc_length. Latency 1.
//   Else if d_ready, d_valid->0. d_pc/d_len hold while d_valid && !d_ready.
//  ras_push: registered 1-cycle pulse on the edge after a fire with dc_is_call.
//   ras_address = f_pc+dc_length, mod 2^IADDRW, so wrap is allowed.
//  HLT: a fire with dc_is_hlt moves RUN->HALT. The HLT is still presented on d_valid.
//   halt=1 from the next edge and no further fires occur.
//  HALT->INT when handle_int=1. INT holds INT_CYCLES cycles using an internal counter,
//   then goes to RUN; halt drops on entry to INT.
//  handle_int in RUN: RUN->INT after the current fire completes. Fires are blocked in INT.
//  flush has top priority. On the next edge d_valid=0, ras_push=0, INT counter cleared, and
//   RUN/INT go to FLUSH. HALT stays HALT. FLUSH lasts 1 cycle, with no fire, then returns to RUN.
//  Simultaneous flush and handle_int: flush wins. handle_int must be held until INT is entered.
//  starve_cnt +1 each RUN cycle with f_valid && dc_length>f_valid_bytes. Saturates at all-ones.
//   Cleared only by reset.
//  dc_length 0 or >MAXLEN: no fire, and the cycle does not count toward starve_cnt.
//  Async reset mid-operation: all state returns to reset values immediately. A pending
//   d_valid is dropped.
// STRUCTURE
//  Shared package decode_pkg: state encoding (RUN/HALT/INT/FLUSH), MAXLEN, IADDRW.
//  One sub-module, sat_counter (CNTW, inc, clear), used for starve_cnt.
//  The rest is a single always block for the FSM plus the output register.
// TESTING
//  1 Reset low then high; f_valid=1, bytes=16, len=3, pc=0x100, d_ready=1
//    -> f_bytes_read=3 same cycle; next cycle d_valid=1, d_pc=0x100, d_len=3.
//  2 Backpressure: d_ready=0 with d_valid=1 -> f_ready=0; d_pc holds.
//    d_ready=1 -> fire resumes same cycle.
//  3 Starve: len=7, bytes=4 for 5 cycles -> no fire, starve_cnt=5; bytes=8 -> fire with f_bytes_read=7.
//  4 CALL at pc=0xFFFFFFFE, len=5 -> ras_push pulse 1 cycle, ras_address=0x3.
//  5 HLT fires -> halt=1, no fires. handle_int=1 -> INT for 2 cycles, halt=0, then RUN fires again.
//  6 flush with d_valid=1 in RUN -> d_valid=0 next edge, FLUSH 1 cycle, f_ready=0 for 2 cycles.
//    Async reset asserted mid-HLT -> halt=0 immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode-stage sequencer: controller states and
// default sizing for the instruction address and the longest legal instruction.
package decode_pkg;

   localparam int IADDRW_DEF = 32;
   localparam int MAXLEN_DEF = 15;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1,
      S_INT   = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

endpackage

// File: rtl/decode_seq_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear, used to count starved
// decode cycles. It sticks at all-ones rather than wrapping back to zero.
module sat_counter #(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inc,
   input  logic            clear,
   output logic [CNTW-1:0] count
);

   // Count up on inc, stop at all-ones, clear takes priority over inc
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {CNTW{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/decode_seq_ctrl.sv
// Decode-stage sequencer: accepts one instruction per cycle from the fetch
// window, holds it in the output register for downstream, pulses the return
// address stack on CALLs and runs the RUN/HALT/INT/FLUSH control machine.
module decode_seq_ctrl
   import decode_pkg::*;
#(
   parameter int IADDRW     = IADDRW_DEF,
   parameter int MAXLEN     = MAXLEN_DEF,
   parameter int INT_CYCLES = 2,
   parameter int CNTW       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              handle_int,
   output logic              halt,
   input  logic              f_valid,
   input  logic [5:0]        f_valid_bytes,
   input  logic [IADDRW-1:0] f_pc,
   output logic              f_ready,
   output logic [5:0]        f_bytes_read,
   input  logic [3:0]        dc_length,
   input  logic              dc_is_hlt,
   input  logic              dc_is_call,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [IADDRW-1:0] d_pc,
   output logic [3:0]        d_len,
   output logic              ras_push,
   output logic [IADDRW-1:0] ras_address,
   output logic [CNTW-1:0]   starve_cnt
);

   state_t     state;
   state_t     state_next;
   logic [3:0] int_cnt;
   logic [3:0] int_cnt_next;

   logic len_legal;
   logic len_fits;
   logic fire;
   logic starved;

   // A length of zero or beyond MAXLEN is a decoder fault, never a fire and
   // never a starved cycle; otherwise the window must hold the whole instruction.
   assign len_legal = (dc_length != 4'd0) && ({1'b0, dc_length} <= 5'(MAXLEN));
   assign len_fits  = ({2'b00, dc_length} <= f_valid_bytes);

   assign fire = (state == S_RUN) && f_valid && len_legal && len_fits
                 && (!d_valid || d_ready) && !flush;

   assign starved = (state == S_RUN) && f_valid && len_legal && !len_fits;

   assign f_ready      = fire;
   assign f_bytes_read = fire ? {2'b00, dc_length} : 6'd0;
   assign halt         = (state == S_HALT);

   // Next-state selection; flush overrides everything except a halted core
   always_comb begin
      state_next   = state;
      int_cnt_next = 4'd0;
      case (state)
         S_RUN: begin
            if (flush) begin
               state_next = S_FLUSH;
            end else if (fire && dc_is_hlt) begin
               state_next = S_HALT;
            end else if (handle_int) begin
               state_next = S_INT;
            end
         end
         S_HALT: begin
            if (handle_int && !flush) begin
               state_next = S_INT;
            end
         end
         S_INT: begin
            if (flush) begin
               state_next = S_FLUSH;
            end else if (int_cnt == 4'(INT_CYCLES - 1)) begin
               state_next = S_RUN;
            end else begin
               int_cnt_next = int_cnt + 4'd1;
            end
         end
         S_FLUSH: begin
            if (!flush) begin
               state_next = S_RUN;
            end
         end
         default: begin
            state_next = S_RUN;
         end
      endcase
   end

   // Control state and the interrupt dwell counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_RUN;
         int_cnt <= 4'd0;
      end else begin
         state   <= state_next;
         int_cnt <= int_cnt_next;
      end
   end

   // Output pipe register and RAS pulse; the held instruction is frozen
   // while downstream stalls, and a flush drops it outright
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_valid     <= 1'b0;
         d_pc        <= '0;
         d_len       <= 4'd0;
         ras_push    <= 1'b0;
         ras_address <= '0;
      end else begin
         ras_push <= fire && dc_is_call;
         if (fire && dc_is_call) begin
            ras_address <= f_pc + IADDRW'(dc_length);
         end
         if (flush) begin
            d_valid <= 1'b0;
         end else if (fire) begin
            d_valid <= 1'b1;
            d_pc    <= f_pc;
            d_len   <= dc_length;
         end else if (d_ready) begin
            d_valid <= 1'b0;
         end
      end
   end

   sat_counter #(
      .CNTW (CNTW)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc   (starved),
      .clear (1'b0),
      .count (starve_cnt)
   );

endmodule

// File: tb/tb_decode_seq_ctrl.sv
// Self-checking bench for decode_seq_ctrl: directed scenarios followed by a
// randomized run compared against a behavioural model of the controller.
module tb_decode_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        handle_int;
   logic        halt;
   logic        f_valid;
   logic [5:0]  f_valid_bytes;
   logic [31:0] f_pc;
   logic        f_ready;
   logic [5:0]  f_bytes_read;
   logic [3:0]  dc_length;
   logic        dc_is_hlt;
   logic        dc_is_call;
   logic        d_valid;
   logic        d_ready;
   logic [31:0] d_pc;
   logic [3:0]  d_len;
   logic        ras_push;
   logic [31:0] ras_address;
   logic [15:0] starve_cnt;

   int errors = 0;
   int checks = 0;

   decode_seq_ctrl #(
      .IADDRW     (32),
      .MAXLEN     (15),
      .INT_CYCLES (2),
      .CNTW       (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .handle_int    (handle_int),
      .halt          (halt),
      .f_valid       (f_valid),
      .f_valid_bytes (f_valid_bytes),
      .f_pc          (f_pc),
      .f_ready       (f_ready),
      .f_bytes_read  (f_bytes_read),
      .dc_length     (dc_length),
      .dc_is_hlt     (dc_is_hlt),
      .dc_is_call    (dc_is_call),
      .d_valid       (d_valid),
      .d_ready       (d_ready),
      .d_pc          (d_pc),
      .d_len         (d_len),
      .ras_push      (ras_push),
      .ras_address   (ras_address),
      .starve_cnt    (starve_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; handle_int = 0; f_valid = 0; f_valid_bytes = 0; f_pc = 0;
      dc_length = 0; dc_is_hlt = 0; dc_is_call = 0; d_ready = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 0;
      tick(); tick();
      checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt got=%0b exp=0", halt); end
      checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dvalid got=%0b exp=0", d_valid); end
      checks++; if (ras_push !== 1'b0 || ras_address !== 32'h0) begin errors++; $display("[TB] FAIL reset_ras got=%0b/%h exp=0/0", ras_push, ras_address); end
      checks++; if (starve_cnt !== 16'h0 || d_pc !== 32'h0 || d_len !== 4'h0) begin errors++; $display("[TB] FAIL reset_regs got=%0d/%h/%0d exp=0/0/0", starve_cnt, d_pc, d_len); end
      reset = 1;
      f_valid = 1; f_valid_bytes = 16; dc_length = 3; f_pc = 32'h100; d_ready = 1;
      #1;
      checks++; if (f_ready !== 1'b1 || f_bytes_read !== 6'd3) begin errors++; $display("[TB] FAIL first_fire got=%0b/%0d exp=1/3", f_ready, f_bytes_read); end
      tick();
      checks++; if (d_valid !== 1'b1 || d_pc !== 32'h100 || d_len !== 4'd3) begin errors++; $display("[TB] FAIL first_out got=%0b/%h/%0d exp=1/100/3", d_valid, d_pc, d_len); end
   endtask

   task automatic test_backpressure();
      d_ready = 0; f_pc = 32'h200; dc_length = 4;
      #1;
      checks++; if (f_ready !== 1'b0 || f_bytes_read !== 6'd0) begin errors++; $display("[TB] FAIL bp_block got=%0b/%0d exp=0/0", f_ready, f_bytes_read); end
      tick();
      checks++; if (d_valid !== 1'b1 || d_pc !== 32'h100 || d_len !== 4'd3) begin errors++; $display("[TB] FAIL bp_hold got=%0b/%h/%0d exp=1/100/3", d_valid, d_pc, d_len); end
      d_ready = 1;
      #1;
      checks++; if (f_ready !== 1'b1 || f_bytes_read !== 6'd4) begin errors++; $display("[TB] FAIL bp_resume got=%0b/%0d exp=1/4", f_ready, f_bytes_read); end
      tick();
      checks++; if (d_valid !== 1'b1 || d_pc !== 32'h200 || d_len !== 4'd4) begin errors++; $display("[TB] FAIL bp_next got=%0b/%h/%0d exp=1/200/4", d_valid, d_pc, d_len); end
   endtask

   task automatic test_starve();
      dc_length = 7; f_valid_bytes = 4; f_pc = 32'h300;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (f_ready !== 1'b0) begin errors++; $display("[TB] FAIL starve_nofire cyc=%0d got=%0b exp=0", i, f_ready); end
         tick();
      end
      checks++; if (starve_cnt !== 16'd5) begin errors++; $display("[TB] FAIL starve_count got=%0d exp=5", starve_cnt); end
      f_valid_bytes = 8;
      #1;
      checks++; if (f_ready !== 1'b1 || f_bytes_read !== 6'd7) begin errors++; $display("[TB] FAIL starve_fire got=%0b/%0d exp=1/7", f_ready, f_bytes_read); end
      tick();
      checks++; if (starve_cnt !== 16'd5) begin errors++; $display("[TB] FAIL starve_hold got=%0d exp=5", starve_cnt); end
      dc_length = 0; f_valid_bytes = 0;
      #1;
      checks++; if (f_ready !== 1'b0) begin errors++; $display("[TB] FAIL len0_nofire got=%0b exp=0", f_ready); end
      tick();
      checks++; if (starve_cnt !== 16'd5) begin errors++; $display("[TB] FAIL len0_nocount got=%0d exp=5", starve_cnt); end
   endtask

   task automatic test_call_wrap();
      f_valid = 1; f_valid_bytes = 16; dc_length = 5; f_pc = 32'hFFFF_FFFE; dc_is_call = 1; d_ready = 1;
      tick();
      checks++; if (ras_push !== 1'b1 || ras_address !== 32'h3) begin errors++; $display("[TB] FAIL call_push got=%0b/%h exp=1/3", ras_push, ras_address); end
      dc_is_call = 0; f_valid = 0;
      tick();
      checks++; if (ras_push !== 1'b0) begin errors++; $display("[TB] FAIL call_pulse got=%0b exp=0", ras_push); end
   endtask

   task automatic test_halt_int();
      f_valid = 1; f_valid_bytes = 16; dc_length = 1; f_pc = 32'h400; dc_is_hlt = 1;
      #1;
      checks++; if (f_ready !== 1'b1) begin errors++; $display("[TB] FAIL hlt_fire got=%0b exp=1", f_ready); end
      tick();
      checks++; if (halt !== 1'b1 || d_valid !== 1'b1 || d_pc !== 32'h400) begin errors++; $display("[TB] FAIL hlt_enter got=%0b/%0b/%h exp=1/1/400", halt, d_valid, d_pc); end
      dc_is_hlt = 0; f_pc = 32'h401;
      #1;
      checks++; if (f_ready !== 1'b0) begin errors++; $display("[TB] FAIL halt_nofire got=%0b exp=0", f_ready); end
      tick();
      checks++; if (halt !== 1'b1 || f_ready !== 1'b0) begin errors++; $display("[TB] FAIL halt_stay got=%0b/%0b exp=1/0", halt, f_ready); end
      handle_int = 1;
      tick();
      handle_int = 0;
      #1;
      checks++; if (halt !== 1'b0 || f_ready !== 1'b0) begin errors++; $display("[TB] FAIL int_cyc1 got=%0b/%0b exp=0/0", halt, f_ready); end
      tick();
      checks++; if (f_ready !== 1'b0) begin errors++; $display("[TB] FAIL int_cyc2 got=%0b exp=0", f_ready); end
      tick();
      checks++; if (f_ready !== 1'b1) begin errors++; $display("[TB] FAIL int_resume got=%0b exp=1", f_ready); end
   endtask

   task automatic test_flush();
      tick();
      checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre got=%0b exp=1", d_valid); end
      flush = 1;
      #1;
      checks++; if (f_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_cyc0 got=%0b exp=0", f_ready); end
      tick();
      flush = 0;
      #1;
      checks++; if (d_valid !== 1'b0 || f_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_cyc1 got=%0b/%0b exp=0/0", d_valid, f_ready); end
      tick();
      checks++; if (f_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_done got=%0b exp=1", f_ready); end
   endtask

   task automatic test_async_reset();
      dc_is_hlt = 1;
      tick();
      dc_is_hlt = 0;
      checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL ar_halt got=%0b exp=1", halt); end
      #2;
      reset = 0;
      #1;
      checks++; if (halt !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_immediate got=%0b/%0b exp=0/0", halt, d_valid); end
      tick();
      reset = 1;
   endtask

   // Randomized run against a behavioural model of the controller rules
   task automatic test_random();
      int          m_mode;
      int          int_left;
      bit          m_dv, m_push, exp_fire, len_ok;
      logic [31:0] m_pc, m_ras;
      int          m_len, m_starve, len, bytes;
      idle_inputs();
      reset = 0;
      tick();
      reset = 1;
      m_mode = 0; int_left = 0; m_dv = 0; m_push = 0; m_pc = 0; m_ras = 0; m_len = 0; m_starve = 0;
      for (int c = 0; c < 400; c++) begin
         f_valid       = ($urandom_range(0, 3) != 0);
         bytes         = $urandom_range(0, 32);
         len           = $urandom_range(0, 15);
         f_valid_bytes = 6'(bytes);
         dc_length     = 4'(len);
         f_pc          = $urandom;
         dc_is_hlt     = ($urandom_range(0, 15) == 0);
         dc_is_call    = ($urandom_range(0, 3) == 0);
         d_ready       = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 19) == 0);
         handle_int    = ($urandom_range(0, 7) == 0);
         #1;
         len_ok   = (len >= 1) && (len <= 15);
         exp_fire = (m_mode == 0) && f_valid && len_ok && (len <= bytes) && (!m_dv || d_ready) && !flush;
         checks++; if (f_ready !== exp_fire || f_bytes_read !== (exp_fire ? 6'(len) : 6'd0)) begin errors++; $display("[TB] FAIL rnd_fready cyc=%0d got=%0b/%0d exp=%0b/%0d", c, f_ready, f_bytes_read, exp_fire, exp_fire ? len : 0); end
         if (m_mode == 0 && f_valid && len_ok && len > bytes && m_starve < 65535) m_starve++;
         m_push = exp_fire && dc_is_call;
         if (m_push) m_ras = f_pc + 32'(len);
         if (flush) m_dv = 0;
         else if (exp_fire) begin m_dv = 1; m_pc = f_pc; m_len = len; end
         else if (d_ready) m_dv = 0;
         case (m_mode)
            0: if (flush) m_mode = 3;
               else if (exp_fire && dc_is_hlt) m_mode = 1;
               else if (handle_int) begin m_mode = 2; int_left = 2; end
            1: if (handle_int && !flush) begin m_mode = 2; int_left = 2; end
            2: if (flush) m_mode = 3;
               else begin int_left--; if (int_left == 0) m_mode = 0; end
            default: if (!flush) m_mode = 0;
         endcase
         tick();
         checks++; if (halt !== (m_mode == 1) || d_valid !== m_dv) begin errors++; $display("[TB] FAIL rnd_state cyc=%0d got=%0b/%0b exp=%0b/%0b", c, halt, d_valid, m_mode == 1, m_dv); end
         if (m_dv) begin
            checks++; if (d_pc !== m_pc || d_len !== 4'(m_len)) begin errors++; $display("[TB] FAIL rnd_dout cyc=%0d got=%h/%0d exp=%h/%0d", c, d_pc, d_len, m_pc, m_len); end
         end
         checks++; if (ras_push !== m_push || (m_push && ras_address !== m_ras)) begin errors++; $display("[TB] FAIL rnd_ras cyc=%0d got=%0b/%h exp=%0b/%h", c, ras_push, ras_address, m_push, m_ras); end
         checks++; if (starve_cnt !== 16'(m_starve)) begin errors++; $display("[TB] FAIL rnd_starve cyc=%0d got=%0d exp=%0d", c, starve_cnt, m_starve); end
      end
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_starve();
      test_call_wrap();
      test_halt_int();
      test_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
